aes_round_ctrl: RTL and testbench

Round sequencer for the AES-128 encryption datapath. It accepts one block per handshake and issues one-cycle start strobes to the registered round stages: sub_bytes, shift_row, mix_columns, add_round_key and key expansion. It tracks the round number, supplies the round constant, and holds the finished result until the consumer accepts it. It sits between the block-level valid/ready interface and the stage enables of the cipher core.

---
 rtl/aes_round_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//
// Round sequencer for an AES-128 encryption datapath. It accepts one block
// per valid/ready handshake and walks the cipher core through its rounds by
// issuing one-cycle capture strobes to the registered stages. It holds the
// finished ciphertext (out_valid) until the consumer accepts it.
//
// Schedule (T0 = accept cycle):
//   T1                  ARK0  (load + ark_start, round 0)
//   round r < ROUNDS    SB, SR, MC, ARK   (4 cycles)
//   round r = ROUNDS    SB, SR, ARK       (3 cycles, no MixColumns)
//   T(4*ROUNDS+1)       DONE  (out_valid held until out_ready)
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   plaintext and key are present on the datapath inputs
//   in_ready   block accepted this cycle (IDLE, or DONE with out_ready)
//   out_valid  ciphertext in the ARK stage register is final
//   out_ready  consumer takes the ciphertext
//   flush      synchronous abort of the block in flight
//   load       state/key input mux selects plaintext and cipher key
//   sb_start, sr_start, mc_start, ark_start   stage capture strobes
//   key_start  key expansion computes the round key for `round`
//   round      current round number, 0..ROUNDS
//   rcon       round constant for `round` (0 in round 0, IDLE and DONE)
//   busy       a block is in flight
//   blk_cnt    completed blocks, saturating
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int ROUNDS = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        flush,
    output logic        load,
    output logic        sb_start,
    output logic        sr_start,
    output logic        mc_start,
    output logic        ark_start,
    output logic        key_start,
    output logic [3:0]  round,
    output logic [7:0]  rcon,
    output logic        busy,
    output logic [15:0] blk_cnt
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARK0 = 3'd1,
        SB   = 3'd2,
        SR   = 3'd3,
        MC   = 3'd4,
        ARK  = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t      state_reg,   state_next;
    logic [3:0]  round_reg,   round_next;
    logic [15:0] blk_cnt_reg, blk_cnt_next;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            round_reg   <= 4'd0;
            blk_cnt_reg <= 16'd0;
        end else begin
            state_reg   <= state_next;
            round_reg   <= round_next;
            blk_cnt_reg <= blk_cnt_next;
        end
    end

    // Next-state logic and decoded outputs
    always_comb begin
        state_next   = state_reg;
        round_next   = round_reg;
        blk_cnt_next = blk_cnt_reg;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        load         = 1'b0;
        sb_start     = 1'b0;
        sr_start     = 1'b0;
        mc_start     = 1'b0;
        ark_start    = 1'b0;
        key_start    = 1'b0;

        case (state_reg)
            IDLE: begin
                // A flush in IDLE blocks acceptance for that cycle only.
                in_ready = !flush;
                if (in_valid && !flush) begin
                    state_next = ARK0;
                    round_next = 4'd0;
                end
            end
            ARK0: begin
                busy       = 1'b1;
                load       = 1'b1;
                ark_start  = 1'b1;
                state_next = SB;
                round_next = 4'd1;
            end
            SB: begin
                busy       = 1'b1;
                sb_start   = 1'b1;
                key_start  = 1'b1;
                state_next = SR;
            end
            SR: begin
                busy       = 1'b1;
                sr_start   = 1'b1;
                state_next = (round_reg == LAST_ROUND) ? ARK : MC;
            end
            MC: begin
                busy       = 1'b1;
                mc_start   = 1'b1;
                state_next = ARK;
            end
            ARK: begin
                busy      = 1'b1;
                ark_start = 1'b1;
                if (round_reg == LAST_ROUND) begin
                    state_next = DONE;
                    if (blk_cnt_reg != 16'hFFFF) begin
                        blk_cnt_next = blk_cnt_reg + 16'd1;
                    end
                end else begin
                    state_next = SB;
                    round_next = round_reg + 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // A new block is only taken when the current one leaves.
                in_ready  = out_ready && !flush;
                if (out_ready) begin
                    state_next = in_valid ? ARK0 : IDLE;
                    round_next = 4'd0;
                end
            end
            default: begin
                state_next = IDLE;
                round_next = 4'd0;
            end
        endcase

        // Abort wins over every other transition, including the DONE
        // handshake; the completed-block count is left untouched.
        if (flush && state_reg != IDLE) begin
            state_next   = IDLE;
            round_next   = 4'd0;
            blk_cnt_next = blk_cnt_reg;
        end
    end

    // Round constant: only meaningful while a round is being computed.
    always_comb begin
        rcon = 8'h00;
        if (state_reg != IDLE && state_reg != DONE) begin
            case (round_reg)
                4'd1:    rcon = 8'h01;
                4'd2:    rcon = 8'h02;
                4'd3:    rcon = 8'h04;
                4'd4:    rcon = 8'h08;
                4'd5:    rcon = 8'h10;
                4'd6:    rcon = 8'h20;
                4'd7:    rcon = 8'h40;
                4'd8:    rcon = 8'h80;
                4'd9:    rcon = 8'h1B;
                4'd10:   rcon = 8'h36;
                default: rcon = 8'h00;
            endcase
        end
    end

    assign round   = round_reg;
    assign blk_cnt = blk_cnt_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Bench for aes_round_ctrl. A behavioural AES-128 datapath driven by the
// controller's strobes checks the FIPS-197 example ciphertext. Directed
// vector table for the first block, hand-written corner sequences, then
// random traffic compared against a cycle-offset reference model.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    localparam int R = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        load;
    logic        sb_start, sr_start, mc_start, ark_start, key_start;
    logic [3:0]  round;
    logic [7:0]  rcon;
    logic        busy;
    logic [15:0] blk_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.ROUNDS(R)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .load      (load),
        .sb_start  (sb_start),
        .sr_start  (sr_start),
        .mc_start  (mc_start),
        .ark_start (ark_start),
        .key_start (key_start),
        .round     (round),
        .rcon      (rcon),
        .busy      (busy),
        .blk_cnt   (blk_cnt)
    );

    // ------------------------------------------------------------------
    // Behavioural AES-128 datapath (byte 0 = MSB, column-major state)
    // ------------------------------------------------------------------
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [127:0] st = '0;
    logic [127:0] rk = '0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] v = b;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
        return v;
    endfunction

    // S-box from first principles: inverse x^254 in GF(2^8), then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = x;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), x);
        r = gmul(r, r);
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
        return v[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] v);
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(byte_of(v, i));
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] v);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = byte_of(v, r + 4*((c + r) % 4));
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] v);
        logic [127:0] o = '0;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = byte_of(v, 4*c);   a1 = byte_of(v, 4*c+1);
            a2 = byte_of(v, 4*c+2); a3 = byte_of(v, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
            o[127-8*(4*c+3) -: 8] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    always @(posedge clk) begin
        if (ark_start) begin
            if (load) begin
                st <= PT ^ KEY;
                rk <= KEY;
            end else begin
                st <= st ^ rk;
            end
        end
        if (sb_start)  st <= sub_bytes(st);
        if (sr_start)  st <= shift_rows(st);
        if (mc_start)  st <= mix_cols(st);
        if (key_start) rk <= key_exp(rk, rcon);
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [36:0] outs();
        return {in_ready, out_valid, busy, load, sb_start, sr_start, mc_start,
                ark_start, key_start, round, rcon, blk_cnt};
    endfunction

    function automatic logic [4:0] strobes();
        return {load, sb_start, sr_start, mc_start, ark_start};
    endfunction

    logic [7:0] rtab [0:10];

    // ------------------------------------------------------------------
    // Reference model: position in the schedule as a plain cycle offset
    // k = cycles since accept; derives round/stage arithmetically.
    // ------------------------------------------------------------------
    int m_phase = 0;   // 0 idle, 1 computing, 2 holding result
    int m_k     = 0;
    int m_cnt   = 0;

    function automatic logic [36:0] model_out(input logic iv, input logic ordy, input logic fl);
        logic ir = 0, ov = 0, bz = 0, ld = 0, sb = 0, sr = 0, mc = 0, ak = 0, ks = 0;
        int rr = 0, pp;
        logic [7:0] rc = 8'h00;
        if (m_phase == 0) begin
            ir = !fl;
        end else if (m_phase == 1) begin
            bz = 1;
            if (m_k == 1) begin
                ld = 1; ak = 1;
            end else begin
                rr = (m_k - 2) / 4 + 1;
                pp = (m_k - 2) % 4;
                rc = rtab[rr];
                if (pp == 0) begin sb = 1; ks = 1; end
                else if (pp == 1) sr = 1;
                else if (pp == 2 && rr < R) mc = 1;
                else ak = 1;
            end
        end else begin
            ov = 1; rr = R; ir = ordy && !fl;
        end
        return {ir, ov, bz, ld, sb, sr, mc, ak, ks, 4'(rr), rc, 16'(m_cnt)};
    endfunction

    task automatic model_step(input logic iv, input logic ordy, input logic fl);
        if (m_phase == 0) begin
            if (iv && !fl) begin m_phase = 1; m_k = 1; end
        end else if (fl) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            if (m_k == 4*R) begin
                m_phase = 2;
                if (m_cnt < 65535) m_cnt++;
            end else m_k++;
        end else if (ordy) begin
            if (iv) begin m_phase = 1; m_k = 1; end
            else m_phase = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table for the first block
    // ------------------------------------------------------------------
    typedef struct {
        int         t;
        logic [4:0] strb;    // {load, sb, sr, mc, ark}
        logic       ks;
        logic       ov;
        logic [3:0] rnd;
        logic [7:0] rc;
    } vec_t;

    vec_t tab [10];

    int exp_cnt;
    int mc10;
    int rises [3];
    int nr;
    int n;
    logic prev_ov;
    logic seen_ov;
    logic hit;
    logic [36:0] expv;

    initial begin
        rtab[0] = 8'h00; rtab[1] = 8'h01; rtab[2] = 8'h02; rtab[3] = 8'h04;
        rtab[4] = 8'h08; rtab[5] = 8'h10; rtab[6] = 8'h20; rtab[7] = 8'h40;
        rtab[8] = 8'h80; rtab[9] = 8'h1b; rtab[10] = 8'h36;

        tab[0] = '{1,  5'b10001, 1'b0, 1'b0, 4'd0,  8'h00};
        tab[1] = '{2,  5'b01000, 1'b1, 1'b0, 4'd1,  8'h01};
        tab[2] = '{3,  5'b00100, 1'b0, 1'b0, 4'd1,  8'h01};
        tab[3] = '{4,  5'b00010, 1'b0, 1'b0, 4'd1,  8'h01};
        tab[4] = '{5,  5'b00001, 1'b0, 1'b0, 4'd1,  8'h01};
        tab[5] = '{6,  5'b01000, 1'b1, 1'b0, 4'd2,  8'h02};
        tab[6] = '{38, 5'b01000, 1'b1, 1'b0, 4'd10, 8'h36};
        tab[7] = '{39, 5'b00100, 1'b0, 1'b0, 4'd10, 8'h36};
        tab[8] = '{40, 5'b00001, 1'b0, 1'b0, 4'd10, 8'h36};
        tab[9] = '{41, 5'b00000, 1'b0, 1'b1, 4'd10, 8'h00};

        // Reset state
        #12;
        chk("reset_outputs", outs(), {1'b1, 36'h0});
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // --- First block: vector table + FIPS-197 ciphertext ---
        in_valid = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        mc10 = 0;
        for (int t = 1; t <= 41; t++) begin
            if (t > 1) cyc();
            #1;
            if (round == 4'd10 && mc_start) mc10++;
            for (int i = 0; i < 10; i++) begin
                if (tab[i].t == t) begin
                    chk($sformatf("T%0d_strobes", t), {strobes(), key_start, out_valid},
                        {tab[i].strb, tab[i].ks, tab[i].ov});
                    chk($sformatf("T%0d_round_rcon", t), {round, rcon}, {tab[i].rnd, tab[i].rc});
                end
            end
        end
        exp_cnt = 1;
        chk("no_mc_in_final_round", mc10, 0);
        chk("fips197_ciphertext_hi", st[127:64], CT[127:64]);
        chk("fips197_ciphertext_lo", st[63:0], CT[63:0]);
        chk("blk_cnt_after_first", blk_cnt, exp_cnt);

        // --- Consumer stall for 10 cycles ---
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            #1;
            chk($sformatf("stall%0d", i), {out_valid, in_ready, strobes(), key_start, blk_cnt},
                {1'b1, 1'b0, 5'b0, 1'b0, 16'd1});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("done_in_ready_follows_out_ready", in_ready, 1);
        cyc();
        #1;
        chk("release_to_idle", {busy, out_valid, in_ready}, 3'b001);

        // --- Back-to-back blocks ---
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nr = 0;
        prev_ov = 1'b0;
        n = 0;
        while (nr < 3 && n < 200) begin
            cyc();
            n++;
            #1;
            if (prev_ov) chk("b2b_done_to_ark0", {load, ark_start}, 2'b11);
            if (out_valid && !prev_ov) begin
                rises[nr] = n;
                nr++;
                if (nr == 3) in_valid = 1'b0;
            end
            prev_ov = out_valid;
        end
        chk("b2b_three_blocks_seen", nr, 3);
        chk("b2b_spacing_1", rises[1] - rises[0], 41);
        chk("b2b_spacing_2", rises[2] - rises[1], 41);
        exp_cnt += 3;
        chk("b2b_blk_cnt", blk_cnt, exp_cnt);
        cyc();
        #1;
        chk("b2b_idle", busy, 0);

        // --- Flush at T20 ---
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int t = 2; t <= 20; t++) cyc();
        flush = 1'b1;
        #1;
        chk("flush_T20_busy", busy, 1);
        cyc();
        flush = 1'b0;
        #1;
        chk("flush_T21_idle", {busy, out_valid, in_ready, round}, {3'b001, 4'd0});
        seen_ov = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (out_valid) seen_ov = 1'b1;
        end
        chk("flush_no_out_valid", seen_ov, 0);
        chk("flush_blk_cnt", blk_cnt, exp_cnt);

        // --- Flush together with the DONE handshake ---
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int t = 2; t <= 41; t++) cyc();
        #1;
        chk("fd_in_done", out_valid, 1);
        exp_cnt++;
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fd_idle_no_ark0", {busy, load, ark_start, out_valid}, 4'b0000);
        chk("fd_blk_cnt", blk_cnt, exp_cnt);
        cyc();
        #1;
        chk("fd_still_idle", busy, 0);

        // --- Reset mid-block at T15 ---
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int t = 2; t <= 15; t++) cyc();
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_values", outs(), {1'b1, 36'h0});
        cyc();
        reset_n = 1'b1;
        exp_cnt = 0;
        cyc();
        #1;
        chk("after_reset_idle", {busy, blk_cnt}, 17'h0);
        in_valid = 1'b1;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 100) begin
            cyc();
            n++;
            in_valid = 1'b0;
            #1;
            if (out_valid) hit = 1'b1;
        end
        chk("reset_fresh_latency", n, 41);
        exp_cnt = 1;
        chk("reset_fresh_blk_cnt", blk_cnt, exp_cnt);
        out_ready = 1'b1;
        cyc();

        // --- Random traffic against the reference model ---
        m_phase = 0;
        m_cnt   = exp_cnt;
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 63) == 0);
            #1;
            expv = model_out(in_valid, out_ready, flush);
            total++;
            if (outs() !== expv) begin
                bad++;
                $display("FAIL rand_cycle%0d: got %0h expected %0h", i, outs(), expv);
            end
            @(posedge clk);
            model_step(in_valid, out_ready, flush);
            #1;
        end
        $display("random phase: %0d blocks completed", m_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
